// File: rtl/cache_l2_full_assoc.sv
`default_nettype none
// ============================================================================
// Module      : cache_l2_full_assoc
// Description : Second-level cache, 8 lines x 2 words, fully associative,
//               true-LRU replacement, write-through / no-write-allocate.
//               The upstream side serves L1 line reads and word writes. The
//               memory side issues single-word reads and writes. Both sides
//               use req/ack handshakes.
// Ports       : clk, reset (async, active-high)
//               up_req_i/up_we_i/up_addr_i/up_wdata_i  L1 request
//               up_ack_o/up_hit_o/up_rdata_o           L1 response
//               mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o  memory request
//               mem_rdata_i/mem_ack_i                  memory response
//               hit_count_o/miss_count_o  present only when
//               CACHE_L2_STATS_EN is defined
// Revision    : 1.0 - initial release
// ============================================================================
module cache_l2_full_assoc #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16,
    parameter int LINES  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  up_req_i,
    input  logic                  up_we_i,
    input  logic [ADDR_W-1:0]     up_addr_i,
    input  logic [DATA_W-1:0]     up_wdata_i,
    output logic                  up_ack_o,
    output logic                  up_hit_o,
    output logic [2*DATA_W-1:0]   up_rdata_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    input  logic [DATA_W-1:0]     mem_rdata_i,
    input  logic                  mem_ack_i
`ifdef CACHE_L2_STATS_EN
    ,
    output logic [15:0]           hit_count_o,
    output logic [15:0]           miss_count_o
`endif
);

    localparam int IDX_W = 3;
    localparam int TAG_W = ADDR_W - 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOOKUP  = 3'd1,
        S_MEM_RD0 = 3'd2,
        S_MEM_RD1 = 3'd3,
        S_MEM_WR  = 3'd4,
        S_RESP    = 3'd5
    } state_t;

    state_t                 state_q;
    logic                   req_we_q;
    logic [ADDR_W-1:0]      req_addr_q;
    logic [DATA_W-1:0]      req_wdata_q;
    logic [DATA_W-1:0]      word0_q;

    logic                   valid_q [LINES];
    logic [TAG_W-1:0]       tag_q   [LINES];
    logic [2*DATA_W-1:0]    data_q  [LINES];
    logic [2:0]             age_q   [LINES];

    logic                   up_ack_q;
    logic                   up_hit_q;
    logic [2*DATA_W-1:0]    up_rdata_q;
    logic                   mem_req_q;
    logic                   mem_we_q;
    logic [ADDR_W-1:0]      mem_addr_q;
    logic [DATA_W-1:0]      mem_wdata_q;

    logic                   lkp_hit;
    logic [IDX_W-1:0]       lkp_idx;
    logic                   vic_free;
    logic [IDX_W-1:0]       vic_idx;

    // Tag match and victim selection. The victim loop walks downward so the
    // lowest-index invalid line is the last (winning) assignment.
    always_comb begin
        lkp_hit  = 1'b0;
        lkp_idx  = '0;
        vic_free = 1'b0;
        vic_idx  = '0;
        for (int i = 0; i < LINES; i++) begin
            if (valid_q[i] && (tag_q[i] == req_addr_q[ADDR_W-1:1])) begin
                lkp_hit = 1'b1;
                lkp_idx = IDX_W'(i);
            end
        end
        for (int i = LINES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                vic_free = 1'b1;
                vic_idx  = IDX_W'(i);
            end
        end
        if (!vic_free) begin
            for (int i = 0; i < LINES; i++) begin
                if (age_q[i] == 3'd7) begin
                    vic_idx = IDX_W'(i);
                end
            end
        end
    end

`ifdef CACHE_L2_STATS_EN
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;
    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            word0_q     <= '0;
            up_ack_q    <= 1'b0;
            up_hit_q    <= 1'b0;
            up_rdata_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            for (int i = 0; i < LINES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                data_q[i]  <= '0;
                age_q[i]   <= 3'(i);
            end
`ifdef CACHE_L2_STATS_EN
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
`endif
        end else begin
            up_ack_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (up_req_i) begin
                        req_we_q    <= up_we_i;
                        req_addr_q  <= up_addr_i;
                        req_wdata_q <= up_wdata_i;
                        state_q     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
`ifdef CACHE_L2_STATS_EN
                    if (lkp_hit) begin
                        if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
                    end else begin
                        if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
                    end
`endif
                    if (lkp_hit) begin
                        // Touch: every line younger than the hit line ages by one.
                        for (int i = 0; i < LINES; i++) begin
                            if (age_q[i] < age_q[lkp_idx]) age_q[i] <= age_q[i] + 3'd1;
                        end
                        age_q[lkp_idx] <= 3'd0;
                    end
                    up_hit_q <= lkp_hit;
                    if (req_we_q) begin
                        if (lkp_hit) begin
                            if (req_addr_q[0]) data_q[lkp_idx][2*DATA_W-1:DATA_W] <= req_wdata_q;
                            else               data_q[lkp_idx][DATA_W-1:0]        <= req_wdata_q;
                        end
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= req_addr_q;
                        mem_wdata_q <= req_wdata_q;
                        state_q     <= S_MEM_WR;
                    end else if (lkp_hit) begin
                        up_rdata_q <= data_q[lkp_idx];
                        state_q    <= S_RESP;
                    end else begin
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= {req_addr_q[ADDR_W-1:1], 1'b0};
                        state_q    <= S_MEM_RD0;
                    end
                end
                S_MEM_RD0: begin
                    if (mem_req_q && mem_ack_i) begin
                        mem_req_q  <= 1'b0;
                        word0_q    <= mem_rdata_i;
                        mem_addr_q <= {req_addr_q[ADDR_W-1:1], 1'b1};
                        state_q    <= S_MEM_RD1;
                    end
                end
                S_MEM_RD1: begin
                    // mem_req dropped on the first ack; re-raise for the second word.
                    if (!mem_req_q) begin
                        mem_req_q <= 1'b1;
                    end else if (mem_ack_i) begin
                        mem_req_q        <= 1'b0;
                        valid_q[vic_idx] <= 1'b1;
                        tag_q[vic_idx]   <= req_addr_q[ADDR_W-1:1];
                        data_q[vic_idx]  <= {mem_rdata_i, word0_q};
                        for (int i = 0; i < LINES; i++) begin
                            if (age_q[i] < age_q[vic_idx]) age_q[i] <= age_q[i] + 3'd1;
                        end
                        age_q[vic_idx] <= 3'd0;
                        up_rdata_q     <= {mem_rdata_i, word0_q};
                        up_hit_q       <= 1'b0;
                        state_q        <= S_RESP;
                    end
                end
                S_MEM_WR: begin
                    if (mem_req_q && mem_ack_i) begin
                        mem_req_q <= 1'b0;
                        state_q   <= S_RESP;
                    end
                end
                S_RESP: begin
                    up_ack_q <= 1'b1;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign up_ack_o    = up_ack_q;
    assign up_hit_o    = up_hit_q;
    assign up_rdata_o  = up_rdata_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule
`default_nettype wire
